hash_table_ctrl: RTL and testbench

//   Sequencer for a hash_function-indexed key/value table, on-chip, TABLE_SIZE entries.

---
 rtl/hash_table_pkg.sv | 26 ++
 rtl/hash_table_ctrl_hash.sv | 13 +
 rtl/hash_table_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_hash_table_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/hash_table_pkg.sv
// Shared types for the linear-probing hash table controller: opcodes,
// response status codes and sequencer states.
package hash_table_pkg;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_RSVD   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_NOT_FOUND = 2'b01,
    ST_FULL      = 2'b10,
    ST_ERR       = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_HASH  = 2'b01,
    S_PROBE = 2'b10,
    S_RESP  = 2'b11
  } state_t;

endpackage

// File: rtl/hash_table_ctrl_hash.sv
// Home-slot hash: key modulo the (power-of-two) table size.
module hash_function #(
  parameter int WIDTH      = 32,
  parameter int TABLE_SIZE = 16,
  localparam int IDX_W     = $clog2(TABLE_SIZE)
) (
  input  logic [WIDTH-1:0] key,
  output logic [IDX_W-1:0] idx
);

  assign idx = IDX_W'(key % WIDTH'(TABLE_SIZE));

endmodule

// File: rtl/hash_table_ctrl.sv
// One-at-a-time LOOKUP/INSERT/DELETE sequencer over a flop-based open-addressing
// table with tombstones; probes one slot per cycle from the hashed home slot.
//
// Handshakes: a transfer happens on any posedge where valid && ready are both
// high; the producer holds its payload stable while valid && !ready, and the
// controller holds rsp_* stable in RESP until rsp_ready.
module hash_table_ctrl
  import hash_table_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int VAL_WIDTH  = 16,
  parameter int TABLE_SIZE = 16,
  localparam int IDX_W     = $clog2(TABLE_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [WIDTH-1:0]     req_key,
  input  logic [VAL_WIDTH-1:0] req_val,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_status,
  output logic [VAL_WIDTH-1:0] rsp_val,
  output logic [IDX_W-1:0]     rsp_idx,
  output logic [IDX_W:0]       count,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  state_t                 state_q, state_d;
  op_t                    op_q;
  logic [WIDTH-1:0]       key_q;
  logic [VAL_WIDTH-1:0]   val_q;
  logic [IDX_W-1:0]       idx_q, probe_cnt_q, free_idx_q, home_idx;
  logic                   free_seen_q;
  logic [IDX_W:0]         count_q;

  logic [TABLE_SIZE-1:0]  slot_valid, slot_tomb;
  logic [WIDTH-1:0]       slot_key [TABLE_SIZE];
  logic [VAL_WIDTH-1:0]   slot_val [TABLE_SIZE];

  status_t                rsp_status_q, res_status;
  logic [VAL_WIDTH-1:0]   rsp_val_q, res_val;
  logic [IDX_W-1:0]       rsp_idx_q, res_idx, wr_idx, tgt_idx;

  logic accept, cur_hit, cur_empty, cur_tomb, last_probe, resolve, have_free;
  logic wr_en, del_en, commit;

  hash_function #(.WIDTH(WIDTH), .TABLE_SIZE(TABLE_SIZE)) u_hash (
    .key (key_q),
    .idx (home_idx)
  );

  assign accept     = req_valid && (state_q == S_IDLE);
  assign cur_hit    = slot_valid[idx_q] && (slot_key[idx_q] == key_q);
  assign cur_empty  = !slot_valid[idx_q] && !slot_tomb[idx_q];
  assign cur_tomb   = !slot_valid[idx_q] && slot_tomb[idx_q];
  assign last_probe = (probe_cnt_q == IDX_W'(TABLE_SIZE - 1));
  assign resolve    = cur_hit || cur_empty || last_probe;
  // The slot under the probe counts as free too, so a final-probe tombstone is usable.
  assign have_free  = free_seen_q || cur_empty || cur_tomb;
  assign tgt_idx    = free_seen_q ? free_idx_q : idx_q;
  assign commit     = (state_q == S_PROBE) && resolve;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (req_op == OP_RSVD) ? S_RESP : S_HASH;
      S_HASH:  state_d = S_PROBE;
      S_PROBE: if (resolve) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res_status = ST_NOT_FOUND;
    res_val    = '0;
    res_idx    = '0;
    wr_en      = 1'b0;
    del_en     = 1'b0;
    wr_idx     = idx_q;
    if (cur_hit) begin
      res_status = ST_OK;
      res_idx    = idx_q;
      case (op_q)
        OP_LOOKUP: res_val = slot_val[idx_q];
        OP_INSERT: wr_en   = 1'b1;
        OP_DELETE: del_en  = 1'b1;
        default:   res_status = ST_ERR;
      endcase
    end else if (op_q == OP_INSERT) begin
      if (have_free) begin
        res_status = ST_OK;
        res_idx    = tgt_idx;
        wr_en      = 1'b1;
        wr_idx     = tgt_idx;
      end else begin
        res_status = ST_FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q         <= OP_LOOKUP;
      key_q        <= '0;
      val_q        <= '0;
      idx_q        <= '0;
      probe_cnt_q  <= '0;
      free_idx_q   <= '0;
      free_seen_q  <= 1'b0;
      count_q      <= '0;
      slot_valid   <= '0;
      slot_tomb    <= '0;
      rsp_status_q <= ST_OK;
      rsp_val_q    <= '0;
      rsp_idx_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          op_q  <= op_t'(req_op);
          key_q <= req_key;
          val_q <= req_val;
          if (req_op == OP_RSVD) begin
            rsp_status_q <= ST_ERR;
            rsp_val_q    <= '0;
            rsp_idx_q    <= '0;
          end
        end
        S_HASH: begin
          idx_q       <= home_idx;
          probe_cnt_q <= '0;
          free_idx_q  <= '0;
          free_seen_q <= 1'b0;
        end
        S_PROBE: begin
          if (resolve) begin
            rsp_status_q <= res_status;
            rsp_val_q    <= res_val;
            rsp_idx_q    <= res_idx;
            if (wr_en) begin
              slot_valid[wr_idx] <= 1'b1;
              slot_tomb[wr_idx]  <= 1'b0;
              if (!cur_hit) count_q <= count_q + 1'b1;
            end
            if (del_en) begin
              slot_valid[idx_q] <= 1'b0;
              slot_tomb[idx_q]  <= 1'b1;
              count_q           <= count_q - 1'b1;
            end
          end else begin
            if (cur_tomb && !free_seen_q) begin
              free_seen_q <= 1'b1;
              free_idx_q  <= idx_q;
            end
            idx_q       <= idx_q + IDX_W'(1);
            probe_cnt_q <= probe_cnt_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Key/value payload needs no reset: it is only read behind a valid bit.
  always_ff @(posedge clk) begin
    if (commit && wr_en) begin
      slot_key[wr_idx] <= key_q;
      slot_val[wr_idx] <= val_q;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign rsp_status = rsp_status_q;
  assign rsp_val    = rsp_val_q;
  assign rsp_idx    = rsp_idx_q;
  assign count      = count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_hash_table_ctrl.sv
// Bench for hash_table_ctrl: directed vector table, hand-written corner sequences,
// and random ops checked against an array-based reference of the probing rules.
module tb_hash_table_ctrl;

  localparam int EW = 35;  // {status, val, idx, latency[7:0], count[4:0]}

  typedef struct {
    logic [1:0]  op;
    logic [31:0] key;
    logic [15:0] val;
    logic [1:0]  st;
    logic [15:0] rv;
    logic [3:0]  ridx;
    int          lat;
    int          cnt;
  } vec_t;

  logic        clk, rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, busy;
  logic [1:0]  req_op, rsp_status, dbg_state;
  logic [31:0] req_key;
  logic [15:0] req_val, rsp_val;
  logic [3:0]  rsp_idx;
  logic [4:0]  count;

  int checks, errors;
  logic [EW-1:0] exp_q[$];

  bit          m_valid [16];
  bit          m_tomb  [16];
  logic [31:0] m_key   [16];
  logic [15:0] m_val   [16];
  int          m_count;

  hash_table_ctrl #(.WIDTH(32), .VAL_WIDTH(16), .TABLE_SIZE(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_val(req_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_val(rsp_val), .rsp_idx(rsp_idx), .count(count), .busy(busy),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tomb[i] = 0; m_key[i] = '0; m_val[i] = '0;
    end
    m_count = 0;
  endtask

  task automatic model_put(input int s, input logic [31:0] key, input logic [15:0] val,
                           output logic [1:0] st, output logic [3:0] ridx);
    m_valid[s] = 1; m_tomb[s] = 0; m_key[s] = key; m_val[s] = val;
    m_count++;
    st = 2'd0; ridx = 4'(s);
  endtask

  // Reference: walk slots from key%16, tombstones skipped and remembered as insert spots.
  task automatic model_op(input logic [1:0] op, input logic [31:0] key, input logic [15:0] val,
                          output logic [1:0] st, output logic [15:0] rv,
                          output logic [3:0] ridx, output int lat);
    int home, free, i;
    bit done;
    st = 2'd1; rv = '0; ridx = '0; lat = 0; done = 0;
    if (op == 2'd3) begin
      st = 2'd3; lat = 1;
      return;
    end
    home = int'(key % 32'd16);
    free = -1;
    for (int p = 0; p < 16 && !done; p++) begin
      i = (home + p) % 16;
      lat = 3 + p;
      if (m_valid[i] && m_key[i] == key) begin
        done = 1; st = 2'd0; ridx = 4'(i);
        if (op == 2'd0) rv = m_val[i];
        else if (op == 2'd1) m_val[i] = val;
        else begin m_valid[i] = 0; m_tomb[i] = 1; m_count--; end
      end else if (!m_valid[i] && !m_tomb[i]) begin
        done = 1;
        if (op == 2'd1) model_put((free >= 0) ? free : i, key, val, st, ridx);
      end else if (!m_valid[i] && free < 0) begin
        free = i;
      end
    end
    if (!done && op == 2'd1) begin
      if (free >= 0) model_put(free, key, val, st, ridx);
      else st = 2'd2;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] key, input logic [15:0] val,
                        input int hold, input logic [1:0] es, input logic [15:0] ev,
                        input logic [3:0] ei, input int el, input int ec);
    logic [EW-1:0] e;
    int m;
    logic got;
    exp_q.push_back({es, ev, ei, 8'(el), 5'(ec)});
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_op = op; req_key = key; req_val = val;
    @(posedge clk);
    #1;
    req_valid = 0; req_op = 2'($urandom); req_key = $urandom; req_val = 16'($urandom);
    m = 0; got = 0;
    while (!got && m < 40) begin
      @(negedge clk);
      m++;
      got = rsp_valid;
    end
    chk("rsp_timeout", got, 1);
    e = exp_q.pop_front();
    chk("rsp_status", rsp_status, e[34:33]);
    chk("rsp_val", rsp_val, e[32:17]);
    chk("rsp_idx", rsp_idx, e[16:13]);
    chk("latency", m, e[12:5]);
    chk("count", count, e[4:0]);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_outputs", {rsp_status, rsp_val, rsp_idx}, e[34:13]);
    end
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
  endtask

  task automatic model_run(input logic [1:0] op, input logic [31:0] key,
                           input logic [15:0] val, input int hold);
    logic [1:0] st; logic [15:0] rv; logic [3:0] ri; int lat;
    model_op(op, key, val, st, rv, ri, lat);
    run_op(op, key, val, hold, st, rv, ri, lat, m_count);
  endtask

  task automatic apply_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_fields", {rsp_status, rsp_val, rsp_idx}, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1;
    model_reset();
  endtask

  vec_t vecs[12];

  initial begin
    logic [1:0] st; logic [15:0] rv; logic [3:0] ri; int lat;
    checks = 0; errors = 0;
    req_valid = 0; req_op = 0; req_key = 0; req_val = 0; rsp_ready = 0; rst_n = 0;

    vecs[0]  = '{2'd0, 32'h05, 16'h0000, 2'd1, 16'h0000, 4'd0,  3, 0};
    vecs[1]  = '{2'd1, 32'h05, 16'hAAAA, 2'd0, 16'h0000, 4'd5,  3, 1};
    vecs[2]  = '{2'd1, 32'h15, 16'hBBBB, 2'd0, 16'h0000, 4'd6,  4, 2};
    vecs[3]  = '{2'd0, 32'h15, 16'h0000, 2'd0, 16'hBBBB, 4'd6,  4, 2};
    vecs[4]  = '{2'd2, 32'h05, 16'h0000, 2'd0, 16'h0000, 4'd5,  3, 1};
    vecs[5]  = '{2'd0, 32'h15, 16'h0000, 2'd0, 16'hBBBB, 4'd6,  4, 1};
    vecs[6]  = '{2'd1, 32'h25, 16'hCCCC, 2'd0, 16'h0000, 4'd5,  5, 2};
    vecs[7]  = '{2'd1, 32'h0F, 16'h1111, 2'd0, 16'h0000, 4'd15, 3, 3};
    vecs[8]  = '{2'd1, 32'h1F, 16'h2222, 2'd0, 16'h0000, 4'd0,  4, 4};
    vecs[9]  = '{2'd0, 32'h1F, 16'h0000, 2'd0, 16'h2222, 4'd0,  4, 4};
    vecs[10] = '{2'd3, 32'h00, 16'h1234, 2'd3, 16'h0000, 4'd0,  1, 4};
    vecs[11] = '{2'd0, 32'h35, 16'h0000, 2'd1, 16'h0000, 4'd0,  5, 4};

    repeat (2) @(posedge clk);
    apply_reset();

    for (int v = 0; v < 12; v++) begin
      model_op(vecs[v].op, vecs[v].key, vecs[v].val, st, rv, ri, lat);
      run_op(vecs[v].op, vecs[v].key, vecs[v].val, (v == 3) ? 5 : 0,
             vecs[v].st, vecs[v].rv, vecs[v].ridx, vecs[v].lat, vecs[v].cnt);
    end

    // Fill: sixteen keys sharing home slot 3, then overflow and overwrite.
    apply_reset();
    for (int i = 0; i < 16; i++) model_run(2'd1, 32'(16 * i + 3), 16'(i + 16'h100), 0);
    @(negedge clk);
    chk("count_full", count, 16);
    model_op(2'd1, 32'h999, 16'h5555, st, rv, ri, lat);
    run_op(2'd1, 32'h999, 16'h5555, 0, 2'd2, 16'h0000, 4'd0, 18, 16);
    model_run(2'd1, 32'h13, 16'h7777, 2);
    model_run(2'd0, 32'h13, 16'h0000, 0);

    // Reset arriving while a long probe is in flight.
    @(negedge clk);
    req_valid = 1; req_op = 2'd1; req_key = 32'h777; req_val = 16'h4444;
    @(posedge clk);
    #1 req_valid = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("midprobe_busy", busy, 1);
    apply_reset();
    model_run(2'd0, 32'h13, 16'h0000, 0);

    // Random traffic over a small key pool to force collisions, tombstones and FULL.
    for (int n = 0; n < 150; n++) begin
      int r;
      logic [1:0] op;
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'd1 : (r < 7) ? 2'd0 : (r < 9) ? 2'd2 : 2'd3;
      model_run(op, 32'($urandom_range(0, 47)), 16'($urandom),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
